bw_io_dtl_drv_enc: RTL
======================

Name: bw_io_dtl_drv_enc

Overview:
- Transmit-side companion to the DTL boundary-scan observe cell.
- Encodes a core data/output-enable pair, or the EXTEST update-register value, into the three DTL pre-driver controls: q_up_pad, q_dn_pad and q25_dn_pad.
- Sequences pad transitions with break-before-make dead time and a 25%-pulldown soft turn-on stage.
- Contains the 2-bit boundary-scan shift/update register for the pad.

Parameters:
- BBM_CYC, 1, dead (all-off) cycles between opposite drive states; legal range 1..15.
- SOFT_CYC, 1, cycles with only the 25% pulldown enabled before full pulldown; legal range 1..15.

Ports:
- clk  input  1  pad-logic clock.
- arst_l  input  1  asynchronous active-low reset.
- core_d  input  1  core output data.
- core_oe  input  1  core output enable.
- bs_mode  input  1  1 selects the update register as the drive source (EXTEST); 0 selects core_d/core_oe.
- bs_capture  input  1  load the shift register from {core_oe, core_d}.
- bs_shift  input  1  shift the scan register one bit.
- bs_update  input  1  copy the shift register into the update register.
- bs_si  input  1  scan in.
- bs_so  output  1  scan out; equals sr[0].
- q_up_pad  output  1  pullup enable, active-high.
- q_dn_pad  output  1  full pulldown enable, active-low.
- q25_dn_pad  output  1  25% pulldown enable, active-low.
- settled  output  1  1 when the pad controls match the steady encoding of the current target.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (arst_l). While arst_l=0:
  - state=HIZ
  - q_up_pad=0, q_dn_pad=1, q25_dn_pad=1
  - sr=2'b00, upd=2'b00, bs_so=0
  - counter=0
  - settled=1
- Reset deassertion is sampled on the next clk rising edge. Reset mid-transition returns the pad to HIZ immediately (asynchronously).
- Source select: {oe,d} = bs_mode ? upd : {core_oe, core_d}. Sampled every cycle.
- Target decode: HIGH when oe=1 and d=1; LOW when oe=1 and d=0; HIZ when oe=0.
- Output encodings (registered, decoded from state; no combinational path from inputs to pad outputs). Order is up, dn, q25:
  - DRV_HI = 1,1,1
  - DRV_LO = 0,0,0
  - SOFT_LO = 0,1,0
  - HIZ = 0,1,1
  - BBM = 0,1,1
- Round trip: the observe decode (intest_d = q_up_pad; intest_oe = ~q_dn_pad | (q_up_pad & q25_dn_pad)) returns the source {oe,d} in every steady state.
- State transitions, evaluated each clk:
  - HIZ: target HIGH -> DRV_HI; target LOW -> SOFT_LO, counter=SOFT_CYC-1.
  - DRV_HI: target HIZ -> HIZ; target LOW -> BBM, counter=BBM_CYC-1.
  - DRV_LO: target HIZ -> HIZ; target HIGH -> BBM, counter=BBM_CYC-1.
  - SOFT_LO: while target=LOW, decrement the counter; at 0 -> DRV_LO. Target HIZ -> HIZ. Target HIGH -> BBM, counter=BBM_CYC-1.
  - BBM: decrement the counter; at 0, go to the target entry state: HIGH -> DRV_HI, LOW -> SOFT_LO (counter=SOFT_CYC-1), HIZ -> HIZ. A target change during BBM is tracked; the dead time is not restarted.
  - Any target that is equal to the current steady state: hold.
- Latency from a source change to the pad outputs:
  - HIZ->HIGH: 1 cycle.
  - HIZ->LOW: SOFT_CYC+1 cycles to reach DRV_LO.
  - HIGH->LOW: BBM_CYC+SOFT_CYC+1 cycles.
  - LOW->HIGH: BBM_CYC+1 cycles.
  - Any state -> HIZ: 1 cycle.
- settled: registered; 1 in HIZ, DRV_HI or DRV_LO when that state equals the target, 0 otherwise.
- Counter: 4 bits, unsigned, never wraps (the next state is taken at 0).
- Scan register: sr[1] = oe, sr[0] = d.
  - Capture has priority over shift: sr <= {core_oe, core_d}.
  - Shift: sr <= {bs_si, sr[1]}.
  - Update: upd <= sr, using the pre-edge value of sr, independent of a simultaneous shift or capture.
  - A change to upd while bs_mode=1 goes through the sequencer like any other target change.

Decomposition:
- Package bw_io_dtl_pkg:
  - state enum {HIZ, DRV_HI, SOFT_LO, DRV_LO, BBM}.
  - target enum {T_HIZ, T_HIGH, T_LOW}.
  - 3-bit pad-encoding constants ENC_HI, ENC_LO, ENC_SOFT, ENC_OFF.
- Sub-module bw_io_dtl_bscan_reg: sr/upd registers with capture, shift and update, and bs_so.
- Top level: source mux, target decode, sequencer FSM, output register.

Test Plan:
- Reset, then core_oe=1, core_d=1 -> q_up,q_dn,q25 = 1,1,1 after 1 clk; settled=1.
- With BBM_CYC=2, SOFT_CYC=1, from DRV_HI drive core_d=0:
  - Required sequence: 0,1,1 for 2 cycles, then 0,1,0 for 1 cycle, then 0,0,0.
  - settled=0 until the final state.
- From DRV_LO set core_oe=0 -> 0,1,1 after 1 clk. Assert arst_l=0 during a BBM -> outputs 0,1,1 and settled=1 with no clk edge.
- Toggle core_d 1->0->1 on consecutive cycles from DRV_HI -> the pad never shows q_up=1 while q_dn or q25 is 0; it returns to 1,1,1 after the BBM completes.
- Scan path:
  - Capture with core {oe,d}=10 -> bs_so=0.
  - Shift once with bs_si=1 -> bs_so=1; sr=11.
  - Update, then bs_mode=1 -> pad goes to DRV_HI.
  - Assert capture and shift together -> capture wins.
- Round trip: feed q_up_pad/q_dn_pad/q25_dn_pad into the observe decode for each of oe,d = 0x, 10, 11 -> intest_oe,intest_d match oe,d.

Source files
------------

// File: rtl/bw_io_dtl_pkg.sv
// Shared types and pad encodings for the DTL transmit encoder.
// Pad encodings are ordered {q_up_pad, q_dn_pad, q25_dn_pad}.
package bw_io_dtl_pkg;

  typedef enum logic [2:0] {
    HIZ,
    DRV_HI,
    SOFT_LO,
    DRV_LO,
    BBM
  } state_t;

  typedef enum logic [1:0] {
    T_HIZ,
    T_HIGH,
    T_LOW
  } target_t;

  localparam logic [2:0] ENC_HI   = 3'b111;
  localparam logic [2:0] ENC_LO   = 3'b000;
  localparam logic [2:0] ENC_SOFT = 3'b010;
  localparam logic [2:0] ENC_OFF  = 3'b011;

  function automatic target_t decode_target(input logic oe, input logic d);
    if (!oe)
      return T_HIZ;
    return d ? T_HIGH : T_LOW;
  endfunction

  // HIZ and BBM share the all-off encoding.
  function automatic logic [2:0] pad_enc(input state_t s);
    case (s)
      DRV_HI:  return ENC_HI;
      DRV_LO:  return ENC_LO;
      SOFT_LO: return ENC_SOFT;
      default: return ENC_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bw_io_dtl_bscan_reg.sv
// Two-bit boundary-scan shift/update register for one DTL pad.
// sr[1] holds oe, sr[0] holds d; scan out is sr[0].
module bw_io_dtl_bscan_reg
  import bw_io_dtl_pkg::*;
(
  input  logic       clk,
  input  logic       arst_l,
  input  logic       capture,
  input  logic       shift,
  input  logic       update,
  input  logic       si,
  input  logic       core_oe,
  input  logic       core_d,
  output logic [1:0] upd,
  output logic       so
);

  logic [1:0] sr;

  // upd samples the pre-edge sr, so a concurrent shift/capture does not leak in.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      sr  <= 2'b00;
      upd <= 2'b00;
    end else begin
      if (capture)
        sr <= {core_oe, core_d};
      else if (shift)
        sr <= {si, sr[1]};
      if (update)
        upd <= sr;
    end
  end

  assign so = sr[0];

endmodule

// File: rtl/bw_io_dtl_drv_enc.sv
// DTL pad pre-driver encoder: source select, break-before-make and soft
// pulldown sequencing, registered pad controls, plus the pad's scan register.
//
// state   | meaning
// HIZ     | all drivers off, pad released
// DRV_HI  | pullup driving
// SOFT_LO | only the 25% pulldown on, counting down the soft turn-on time
// DRV_LO  | full pulldown driving
// BBM     | dead time between opposite drives, counting down
module bw_io_dtl_drv_enc
  import bw_io_dtl_pkg::*;
#(
  parameter int unsigned BBM_CYC  = 1,
  parameter int unsigned SOFT_CYC = 1
) (
  input  logic clk,
  input  logic arst_l,
  input  logic core_d,
  input  logic core_oe,
  input  logic bs_mode,
  input  logic bs_capture,
  input  logic bs_shift,
  input  logic bs_update,
  input  logic bs_si,
  output logic bs_so,
  output logic q_up_pad,
  output logic q_dn_pad,
  output logic q25_dn_pad,
  output logic settled
);

  localparam logic [3:0] BBM_INIT  = 4'(BBM_CYC - 1);
  localparam logic [3:0] SOFT_INIT = 4'(SOFT_CYC - 1);

  logic [1:0] upd;
  logic [1:0] src;
  target_t    tgt;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] pad;
  logic       settled_nxt;

  bw_io_dtl_bscan_reg u_bscan (
    .clk     (clk),
    .arst_l  (arst_l),
    .capture (bs_capture),
    .shift   (bs_shift),
    .update  (bs_update),
    .si      (bs_si),
    .core_oe (core_oe),
    .core_d  (core_d),
    .upd     (upd),
    .so      (bs_so)
  );

  assign src = bs_mode ? upd : {core_oe, core_d};
  assign tgt = decode_target(src[1], src[0]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      HIZ: begin
        if (tgt == T_HIGH) begin
          state_nxt = DRV_HI;
        end else if (tgt == T_LOW) begin
          state_nxt = SOFT_LO;
          cnt_nxt   = SOFT_INIT;
        end
      end
      DRV_HI: begin
        if (tgt == T_HIZ) begin
          state_nxt = HIZ;
        end else if (tgt == T_LOW) begin
          state_nxt = BBM;
          cnt_nxt   = BBM_INIT;
        end
      end
      DRV_LO: begin
        if (tgt == T_HIZ) begin
          state_nxt = HIZ;
        end else if (tgt == T_HIGH) begin
          state_nxt = BBM;
          cnt_nxt   = BBM_INIT;
        end
      end
      SOFT_LO: begin
        if (tgt == T_HIZ) begin
          state_nxt = HIZ;
        end else if (tgt == T_HIGH) begin
          state_nxt = BBM;
          cnt_nxt   = BBM_INIT;
        end else if (cnt == 4'd0) begin
          state_nxt = DRV_LO;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      BBM: begin
        // Dead time runs to completion; only the exit follows the latest target.
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (tgt == T_HIGH) begin
          state_nxt = DRV_HI;
        end else if (tgt == T_LOW) begin
          state_nxt = SOFT_LO;
          cnt_nxt   = SOFT_INIT;
        end else begin
          state_nxt = HIZ;
        end
      end
      default: begin
        state_nxt = HIZ;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign settled_nxt = (state_nxt == HIZ    && tgt == T_HIZ)
                    || (state_nxt == DRV_HI && tgt == T_HIGH)
                    || (state_nxt == DRV_LO && tgt == T_LOW);

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state   <= HIZ;
      cnt     <= 4'd0;
      pad     <= ENC_OFF;
      settled <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pad     <= pad_enc(state_nxt);
      settled <= settled_nxt;
    end
  end

  assign q_up_pad   = pad[2];
  assign q_dn_pad   = pad[1];
  assign q25_dn_pad = pad[0];

endmodule
